// File: rtl/parser_pkg.sv
// -----------------------------------------------------------------------------
// parser_pkg
// Shared definitions for the packet_parser_n6 header parser:
//   - byte width and fixed header offsets (Ethernet / IPv4 / L4)
//   - EtherType and IP protocol numbers recognised by the parser
//   - bit positions of the parsed-header-status word (phs_o)
//   - parser state enum and the table of fixed capture offsets
// -----------------------------------------------------------------------------
package parser_pkg;

  localparam int BYTE_WIDTH = 8;

  // Fixed byte offsets from the start of the frame
  localparam logic [15:0] ETH_TYPE_OFS = 16'd12;
  localparam logic [15:0] IP_OFS       = 16'd14;  // also the Ethernet header length
  localparam logic [15:0] IP_TLEN_OFS  = 16'd16;
  localparam logic [15:0] IP_PROTO_OFS = 16'd23;

  // Offsets / lengths relative to the L4 header
  localparam logic [15:0] TCP_DOFF_REL = 16'd12;
  localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

  // Smallest legal IHL / TCP data offset, in 32-bit words
  localparam logic [3:0]  MIN_HDR_WORDS = 4'd5;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_TCP      = 8'd6;
  localparam logic [7:0]  PROTO_UDP      = 8'd17;

  // phs_o bit positions
  localparam int PHS_ETH     = 0;
  localparam int PHS_IPV4    = 1;
  localparam int PHS_UDP     = 2;
  localparam int PHS_TCP     = 3;
  localparam int PHS_UNSUP   = 4;
  localparam int PHS_ERR     = 5;
  localparam int PHS_DONE    = 7;
  localparam int PHS_LEN_LSB = 8;
  localparam int PHS_IHL_LSB = 16;

  // Fixed-offset capture slots
  localparam int F_ETH_HI   = 0;
  localparam int F_ETH_LO   = 1;
  localparam int F_VER_IHL  = 2;
  localparam int F_TLEN_HI  = 3;
  localparam int F_TLEN_LO  = 4;
  localparam int F_PROTO    = 5;
  localparam int NUM_FIELDS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ETH,
    ST_IPV4,
    ST_L4,
    ST_DONE
  } state_e;

  // Frame byte offset captured by each fixed slot
  function automatic logic [15:0] field_ofs(input int idx);
    case (idx)
      F_ETH_HI:  field_ofs = ETH_TYPE_OFS;
      F_ETH_LO:  field_ofs = ETH_TYPE_OFS + 16'd1;
      F_VER_IHL: field_ofs = IP_OFS;
      F_TLEN_HI: field_ofs = IP_TLEN_OFS;
      F_TLEN_LO: field_ofs = IP_TLEN_OFS + 16'd1;
      F_PROTO:   field_ofs = IP_PROTO_OFS;
      default:   field_ofs = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/parser_byte_capture.sv
// -----------------------------------------------------------------------------
// parser_byte_capture
// Picks one byte out of a bus word by absolute frame byte offset.
// Ports:
//   word_idx_i   - index of the word currently on the bus
//   bus_i        - bus data, byte lane 0 (first on the wire) in the MSBs
//   target_ofs_i - frame byte offset wanted
//   byte_o       - the byte at target_ofs_i (0 when not in this word)
//   hit_o        - target_ofs_i falls inside this word
// -----------------------------------------------------------------------------
module parser_byte_capture
  import parser_pkg::*;
#(
  parameter int BUS_WIDTH_B = 4
) (
  input  logic [15:0]                       word_idx_i,
  input  logic [BUS_WIDTH_B*BYTE_WIDTH-1:0] bus_i,
  input  logic [15:0]                       target_ofs_i,
  output logic [BYTE_WIDTH-1:0]             byte_o,
  output logic                              hit_o
);

  localparam int LANE_SHIFT = $clog2(BUS_WIDTH_B);

  logic [31:0]            word_base;
  logic [BUS_WIDTH_B-1:0] lane_hit;

  assign word_base = {16'd0, word_idx_i} << LANE_SHIFT;

  generate
    for (genvar gi = 0; gi < BUS_WIDTH_B; gi++) begin : g_lane
      assign lane_hit[gi] = ((word_base + 32'(gi)) == {16'd0, target_ofs_i});
    end
  endgenerate

  // At most one lane can match, so an OR of masked lanes is a clean mux
  always_comb begin
    byte_o = '0;
    for (int k = 0; k < BUS_WIDTH_B; k++) begin
      if (lane_hit[k]) begin
        byte_o = byte_o | bus_i[BYTE_WIDTH*(BUS_WIDTH_B-k)-1 -: BYTE_WIDTH];
      end
    end
  end

  assign hit_o = |lane_hit;

endmodule

// File: rtl/packet_parser_n6.sv
// -----------------------------------------------------------------------------
// packet_parser_n6
// Streaming Ethernet / IPv4 / UDP-TCP header parser, one bus word per clock.
// Ports:
//   CLK               - clock, rising edge
//   reset             - asynchronous active-low reset
//   bus               - packet word; top bit ignored, byte lane 0 in the MSBs
//   start_of_packet_i - marks word 0 of a packet (restarts parsing anywhere)
//   phs_o             - parsed header status (flags, header length, IHL)
//   pay_last_word     - bus-word index holding the last payload byte
// -----------------------------------------------------------------------------
module packet_parser_n6
  import parser_pkg::*;
#(
  parameter int BUS_WIDTH_B = 4
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [BUS_WIDTH_B*BYTE_WIDTH:0] bus,
  input  logic                            start_of_packet_i,
  output logic [31:0]                     phs_o,
  output logic [31:0]                     pay_last_word
);

  localparam int DATA_W     = BUS_WIDTH_B * BYTE_WIDTH;
  localparam int LANE_SHIFT = $clog2(BUS_WIDTH_B);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] phs_q, phs_d;
  logic [31:0] pay_q, pay_d;

  logic [7:0]  fld_q    [NUM_FIELDS];
  logic [7:0]  fld_d    [NUM_FIELDS];
  logic [7:0]  fld_m    [NUM_FIELDS];
  logic [7:0]  fld_byte [NUM_FIELDS];
  logic        fld_hit  [NUM_FIELDS];

  logic [7:0]  tcp_q, tcp_d, tcp_m, tcp_byte;
  logic        tcp_hit;

  logic [DATA_W-1:0] bus_data;
  logic [15:0]       word_idx;
  logic [31:0]       last_byte;
  logic              sop, active;
  logic [8:0]        unused_bits;

  // Decode of the header stack as it stands at the end of the current word
  logic [15:0] ethertype, l4_ofs, tcp_ofs, hdr_len, total_len;
  logic [3:0]  ihl, doff;
  logic        eth_known, is_ip, ihl_known, bad_ihl, proto_known;
  logic        is_udp, is_tcp, unsup_l4, udp_done, tcp_done, tl_known;
  logic        len_ovf, pkt_done, unsup_flag, err_flag;
  logic [7:0]  hdr_len_sat;
  logic [31:0] phs_calc, pay_calc;

  function automatic logic byte_seen(input logic [15:0] ofs, input logic [31:0] last);
    return ({16'd0, ofs} <= last);
  endfunction

  assign bus_data    = bus[DATA_W-1:0];
  assign sop         = start_of_packet_i;
  assign word_idx    = sop ? 16'd0 : cnt_q;
  assign last_byte   = ({16'd0, word_idx} << LANE_SHIFT) + 32'(BUS_WIDTH_B - 1);
  // Words are only consumed while a packet is being parsed (or one starts)
  assign active      = sop || (state_q == ST_ETH) || (state_q == ST_IPV4) || (state_q == ST_L4);
  assign unused_bits = {bus[DATA_W], fld_m[F_VER_IHL][7:4], tcp_m[3:0]};

  // Fixed-offset field captures. fld_m is the value as of the end of this
  // word, so a field arriving in the same word as a later dependent field
  // is usable immediately. On SOP the stale captures read as zero.
  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_fld
      parser_byte_capture #(.BUS_WIDTH_B(BUS_WIDTH_B)) u_cap (
        .word_idx_i   (word_idx),
        .bus_i        (bus_data),
        .target_ofs_i (field_ofs(gi)),
        .byte_o       (fld_byte[gi]),
        .hit_o        (fld_hit[gi])
      );
      assign fld_m[gi] = fld_hit[gi] ? fld_byte[gi] : (sop ? 8'd0 : fld_q[gi]);
      assign fld_d[gi] = active ? fld_m[gi] : fld_q[gi];
    end
  endgenerate

  // TCP data-offset byte sits at a position that depends on IHL
  parser_byte_capture #(.BUS_WIDTH_B(BUS_WIDTH_B)) u_cap_tcp (
    .word_idx_i   (word_idx),
    .bus_i        (bus_data),
    .target_ofs_i (tcp_ofs),
    .byte_o       (tcp_byte),
    .hit_o        (tcp_hit)
  );
  assign tcp_m = (tcp_hit && is_tcp) ? tcp_byte : (sop ? 8'd0 : tcp_q);
  assign tcp_d = active ? tcp_m : tcp_q;

  assign ethertype   = {fld_m[F_ETH_HI], fld_m[F_ETH_LO]};
  assign eth_known   = byte_seen(ETH_TYPE_OFS + 16'd1, last_byte);
  assign is_ip       = eth_known && (ethertype == ETHERTYPE_IPV4);
  assign ihl         = fld_m[F_VER_IHL][3:0];
  assign ihl_known   = is_ip && byte_seen(IP_OFS, last_byte);
  assign bad_ihl     = ihl_known && (ihl < MIN_HDR_WORDS);
  assign l4_ofs      = IP_OFS + {10'd0, ihl, 2'b00};
  assign tcp_ofs     = l4_ofs + TCP_DOFF_REL;
  assign proto_known = ihl_known && !bad_ihl && byte_seen(IP_PROTO_OFS, last_byte);
  assign is_udp      = proto_known && (fld_m[F_PROTO] == PROTO_UDP);
  assign is_tcp      = proto_known && (fld_m[F_PROTO] == PROTO_TCP);
  assign unsup_l4    = proto_known && !is_udp && !is_tcp;
  assign udp_done    = is_udp && byte_seen(l4_ofs, last_byte);
  assign tcp_done    = is_tcp && byte_seen(tcp_ofs, last_byte);
  assign doff        = tcp_m[7:4];
  assign total_len   = {fld_m[F_TLEN_HI], fld_m[F_TLEN_LO]};
  assign tl_known    = is_ip && byte_seen(IP_TLEN_OFS + 16'd1, last_byte);

  // Header length grows as each layer is confirmed
  assign hdr_len = tcp_done    ? (l4_ofs + {10'd0, doff, 2'b00}) :
                   udp_done    ? (l4_ofs + UDP_HDR_LEN) :
                   proto_known ? l4_ofs :
                   eth_known   ? IP_OFS : 16'd0;
  assign len_ovf     = (hdr_len > 16'd255);
  assign hdr_len_sat = len_ovf ? 8'hFF : hdr_len[7:0];

  assign unsup_flag = (eth_known && !is_ip) || unsup_l4;
  assign err_flag   = bad_ihl || (tcp_done && (doff < MIN_HDR_WORDS)) || len_ovf;
  assign pkt_done   = unsup_flag || bad_ihl || udp_done || tcp_done;

  assign pay_calc = tl_known ?
                    (({16'd0, total_len} + {16'd0, IP_OFS} - 32'd1) >> LANE_SHIFT) : 32'd0;

  // State register and datapath flops
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phs_q   <= '0;
      pay_q   <= '0;
      tcp_q   <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        fld_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phs_q   <= phs_d;
      pay_q   <= pay_d;
      tcp_q   <= tcp_d;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        fld_q[i] <= fld_d[i];
      end
    end
  end

  // Word counter: next word after SOP is 1; saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (sop) begin
      cnt_d = 16'd1;
    end else if ((state_q != ST_IDLE) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Next state: jump to the furthest layer reached by the end of this word
  always_comb begin
    state_d = state_q;
    if (active) begin
      if (pkt_done) begin
        state_d = ST_DONE;
      end else if (is_udp || is_tcp) begin
        state_d = ST_L4;
      end else if (is_ip) begin
        state_d = ST_IPV4;
      end else begin
        state_d = ST_ETH;
      end
    end
  end

  // Outputs: re-evaluated while parsing, held once done or idle
  always_comb begin
    phs_calc = '0;
    phs_calc[PHS_ETH]   = eth_known;
    phs_calc[PHS_IPV4]  = is_ip;
    phs_calc[PHS_UDP]   = is_udp;
    phs_calc[PHS_TCP]   = is_tcp;
    phs_calc[PHS_UNSUP] = unsup_flag;
    phs_calc[PHS_ERR]   = err_flag;
    phs_calc[PHS_DONE]  = pkt_done;
    phs_calc[PHS_LEN_LSB +: 8] = hdr_len_sat;
    phs_calc[PHS_IHL_LSB +: 4] = ihl_known ? ihl : 4'd0;

    phs_d = phs_q;
    pay_d = pay_q;
    if (active) begin
      phs_d = phs_calc;
      pay_d = pay_calc;
    end
  end

  assign phs_o         = phs_q;
  assign pay_last_word = pay_q;

endmodule

// File: tb/tb_packet_parser_n6.sv
// -----------------------------------------------------------------------------
// tb_packet_parser_n6
// Directed bench for packet_parser_n6 with a 4-byte bus. Inputs change on the
// falling edge; outputs are sampled on the falling edge after the word of
// interest has been clocked in.
// -----------------------------------------------------------------------------
module tb_packet_parser_n6;

  localparam int W = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic [W*8:0]  bus;
  logic          start_of_packet_i;
  logic [31:0]   phs_o;
  logic [31:0]   pay_last_word;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] pkt [0:127];

  always #5 CLK = ~CLK;

  packet_parser_n6 #(.BUS_WIDTH_B(W)) dut (
    .CLK               (CLK),
    .reset             (reset),
    .bus               (bus),
    .start_of_packet_i (start_of_packet_i),
    .phs_o             (phs_o),
    .pay_last_word     (pay_last_word)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s observed %h expected %h", vectors, tag, obs, exp);
  endtask

  // Applies word w of pkt at the next falling edge; SOP on word 0
  task automatic drive_word(input int w);
    @(negedge CLK);
    start_of_packet_i = (w == 0);
    bus[W*8] = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      bus[8*(W-k)-1 -: 8] = pkt[w*W+k];
    end
  endtask

  // After return, outputs reflect words up to b-1 (word b is on the bus)
  task automatic send_words(input int a, input int b);
    for (int w = a; w <= b; w++) begin
      drive_word(w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      start_of_packet_i = 1'b0;
      bus = {1'($urandom), 32'($urandom)};
    end
  endtask

  task automatic load_ip(input logic [3:0] ihl, input logic [15:0] tl,
                         input logic [7:0] proto, input logic [7:0] tcp_b);
    for (int i = 0; i < 128; i++) pkt[i] = 8'($urandom);
    pkt[12] = 8'h08;
    pkt[13] = 8'h00;
    pkt[14] = {4'h4, ihl};
    pkt[16] = tl[15:8];
    pkt[17] = tl[7:0];
    pkt[23] = proto;
    if (ihl >= 4'd5) pkt[14 + 4*int'(ihl) + 12] = tcp_b;
  endtask

  task automatic load_eth(input logic [15:0] etype);
    for (int i = 0; i < 128; i++) pkt[i] = 8'($urandom);
    pkt[12] = etype[15:8];
    pkt[13] = etype[7:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low with random bus and random SOP
    reset = 1'b0;
    start_of_packet_i = 1'b0;
    bus = '0;
    repeat (4) begin
      @(negedge CLK);
      bus = {1'($urandom), 32'($urandom)};
      start_of_packet_i = 1'($urandom);
    end
    @(negedge CLK);
    check("rst_phs", phs_o, 32'h0);
    check("rst_pay", pay_last_word, 32'h0);
    start_of_packet_i = 1'b0;
    reset = 1'b1;
    idle(5);
    check("idle_phs", phs_o, 32'h0);
    check("idle_pay", pay_last_word, 32'h0);

    // UDP: IHL=5, total_length=43, 57-byte frame = words 0..14
    load_ip(4'd5, 16'd43, 8'd17, 8'h00);
    send_words(0, 4);
    check("udp_w3_phs", phs_o, 32'h0005_0E03);
    check("udp_w3_pay", pay_last_word, 32'd0);
    send_words(5, 5);
    check("udp_w4_pay", pay_last_word, 32'd14);
    send_words(6, 8);
    check("udp_w7_phs", phs_o, 32'h0005_2207);
    send_words(9, 9);
    check("udp_w8_done", phs_o, 32'h0005_2A87);
    send_words(10, 14);
    idle(2);
    check("udp_end_phs", phs_o, 32'h0005_2A87);
    check("udp_end_pay", pay_last_word, 32'd14);

    // TCP: IHL=7, total_length=75, data offset 8, frame = words 0..22
    load_ip(4'd7, 16'd75, 8'd6, 8'h80);
    send_words(0, 5);
    check("tcp_w4_phs", phs_o, 32'h0007_0E03);
    check("tcp_w4_pay", pay_last_word, 32'd22);
    send_words(6, 6);
    check("tcp_w5_proto", phs_o, 32'h0007_2A0B);
    send_words(7, 13);
    check("tcp_w12_phs", phs_o, 32'h0007_2A0B);
    send_words(14, 14);
    check("tcp_w13_done", phs_o, 32'h0007_4A8B);
    send_words(15, 22);
    idle(1);
    check("tcp_end_phs", phs_o, 32'h0007_4A8B);
    check("tcp_end_pay", pay_last_word, 32'd22);

    // Back-to-back: UDP, then TCP SOP right after the last UDP word
    load_ip(4'd5, 16'd43, 8'd17, 8'h00);
    send_words(0, 14);
    load_ip(4'd7, 16'd75, 8'd6, 8'h80);
    send_words(0, 0);
    check("b2b_udp_phs", phs_o, 32'h0005_2A87);
    send_words(1, 1);
    check("b2b_clr_phs", phs_o, 32'h0);
    check("b2b_clr_pay", pay_last_word, 32'h0);
    send_words(2, 22);
    idle(1);
    check("b2b_tcp_phs", phs_o, 32'h0007_4A8B);
    check("b2b_tcp_pay", pay_last_word, 32'd22);

    // Unsupported EtherType
    load_eth(16'h86DD);
    send_words(0, 3);
    check("v6_w2_phs", phs_o, 32'h0);
    send_words(4, 4);
    check("v6_phs", phs_o, 32'h0000_0E91);
    idle(3);
    check("v6_hold_phs", phs_o, 32'h0000_0E91);
    check("v6_pay", pay_last_word, 32'd0);

    // IHL below minimum
    load_ip(4'd3, 16'd40, 8'd17, 8'h00);
    send_words(0, 4);
    check("ihl3_err", {31'd0, phs_o[5]}, 32'd1);
    check("ihl3_done", {31'd0, phs_o[7]}, 32'd1);
    idle(2);

    // SOP in the middle of a UDP header
    load_ip(4'd5, 16'd43, 8'd17, 8'h00);
    send_words(0, 5);
    load_ip(4'd7, 16'd75, 8'd6, 8'h80);
    send_words(0, 1);
    check("mid_sop_phs", phs_o, 32'h0);
    check("mid_sop_pay", pay_last_word, 32'h0);
    send_words(2, 22);
    idle(1);
    check("mid_sop_tcp_phs", phs_o, 32'h0007_4A8B);
    check("mid_sop_tcp_pay", pay_last_word, 32'd22);

    // Reset in the middle of a packet clears outputs without a clock edge
    load_ip(4'd7, 16'd75, 8'd6, 8'h80);
    send_words(0, 8);
    check("mid_rst_pre_pay", pay_last_word, 32'd22);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_phs", phs_o, 32'h0);
    check("mid_rst_pay", pay_last_word, 32'h0);
    @(negedge CLK);
    reset = 1'b1;
    idle(3);
    check("post_rst_phs", phs_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
